spi_apb_cmd_sequencer: RTL and testbench
========================================

Name: spi_apb_cmd_sequencer

Overview:
- APB master that sequences multi-byte SPI transactions on the SPI master's APB slave port (8-bit address/data).
- Accepts one command descriptor (up to 6 bytes, each marked write or read) over valid/ready.
- Issues the per-byte APB register sequence (TX load, start, busy poll, RX capture) and returns the collected read bytes over valid/ready.
- Sits between a system-side requester and the SPI master's paddr/psel/penable/pwrite/pwdata/pready/prdata port.

Parameters:
- POLL_MAX, 64, maximum STATUS reads per byte before timeout (must be ≥1).
- DUMMY_BYTE, 8'hFF, TX value loaded for read bytes.

Ports:
- clk_i  in  1  clock
- aresetn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command descriptor valid
- cmd_ready_o  out  1  sequencer can accept a command
- cmd_len_i  in  3  byte count; legal 1..6
- cmd_bytes_i  in  48  byte k at [8k+7:8k]
- cmd_is_write_i  in  6  bit k=1: byte k is transmit-only; 0: read, capture RX
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  48  RX byte k at [8k+7:8k]; 0 for write bytes and unexecuted bytes
- rsp_err_o  out  1  1 = illegal length or poll timeout
- paddr_o  out  8  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  8  APB write data
- pready_i  in  1  APB ready
- prdata_i  in  8  APB read data

Behaviour:
- SPI master register map: 0x00 TXDATA (W), 0x01 RXDATA (R), 0x02 CTRL (W; bit0 START, bit1 LAST = deassert CS after this byte, bit2 ABORT), 0x03 STATUS (R; bit0 BUSY).
- Reset, asynchronous: all outputs 0, FSM to IDLE, rsp_data_o cleared. cmd_ready_o rises on the first clk_i edge after aresetn_i deasserts.
- Reset mid-transaction: psel_o and penable_o drop immediately; the command is lost and no response is issued.
- States:
  - IDLE: cmd_ready_o=1.
  - SETUP: psel=1, penable=0, exactly 1 cycle.
  - ACCESS: psel=1, penable=1; held until pready_i=1, which completes the transfer on that edge.
  - RESP: rsp_valid_o=1 until rsp_ready_i; returns to IDLE on the following edge. cmd_ready_o=0 in all states except IDLE.
- Command accept: cmd_valid_i & cmd_ready_o on an edge latches len, bytes and mask; the next state is SETUP.
- Illegal cmd_len_i (0 or 7): go directly to RESP with rsp_err_o=1, rsp_data_o=0, no APB activity.
- Per-byte step order for byte k:
  1. Write TXDATA with the byte (write) or DUMMY_BYTE (read).
  2. Write CTRL = {0, k==len-1, 1}.
  3. Read STATUS until BUSY=0.
  4. Read RXDATA only if it is a read byte; store prdata_i into byte k.
- Transfer chaining: after each ACCESS completion the next step's SETUP follows in the next cycle, with no idle cycle between transfers. After the last byte's final step, go to RESP.
- Address, write and data outputs are stable from SETUP through the end of ACCESS. pwdata_o is 0 during reads and in IDLE/RESP.
- Poll counter: reset per byte; counts STATUS completions with BUSY=1. When the count reaches POLL_MAX:
  - Write CTRL=8'h04 (ABORT).
  - Go to RESP with rsp_err_o=1.
  - rsp_data_o keeps the bytes captured so far.
- Zero-wait latency: a 1-byte write accepted at edge 0 occupies APB cycles 1–6; rsp_valid_o=1 in cycle 7 if the first STATUS read returns BUSY=0.
- cmd_valid_i asserted while busy is ignored, with no queueing.
- rsp_data_o and rsp_err_o are held stable while rsp_valid_o=1 and rsp_ready_i=0.

Test Plan:
- Reset, then a 1-byte write of 0xA5, pready=1, STATUS=0x00 → APB sequence W00=A5, W02=03, R03; rsp_valid in cycle 7; rsp_err=0; rsp_data=0.
- 3 bytes {0x9F, rd, rd}, mask=3'b001, RX returns 0xC2, 0x20:
  - CTRL writes are 01, 01, 03.
  - TXDATA for bytes 1 and 2 is FF.
  - rsp_data[23:0]=0x20C200.
- pready low for 3 cycles on each ACCESS → psel/penable and addr/data held until pready; response data identical to the zero-wait run.
- STATUS BUSY=1 for all reads with POLL_MAX=4 → exactly 4 STATUS reads, then W02=04; rsp_err=1.
- cmd_len=0, then cmd_len=7 → immediate rsp_err=1 each time; psel never asserted.
- aresetn_i pulsed low during the second byte's poll → psel/penable go 0 asynchronously; no rsp_valid; the next command then executes normally.

Source files
------------

// File: rtl/spi_apb_cmd_sequencer.sv
// APB master that turns one multi-byte SPI command descriptor into the
// register sequence of an SPI master peripheral (TX load, start, busy poll,
// RX capture) and returns the collected read bytes over valid/ready.
module spi_apb_cmd_sequencer #(
  parameter int          POLL_MAX   = 64,
  parameter logic [7:0]  DUMMY_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        aresetn_i,
  // command descriptor
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_len_i,
  input  logic [47:0] cmd_bytes_i,
  input  logic [5:0]  cmd_is_write_i,
  // response
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [47:0] rsp_data_o,
  output logic        rsp_err_o,
  // APB master towards the SPI peripheral
  output logic [7:0]  paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  pwdata_o,
  input  logic        pready_i,
  input  logic [7:0]  prdata_i
);

  // SPI master register map
  localparam logic [7:0] ADDR_TX     = 8'h00;
  localparam logic [7:0] ADDR_RX     = 8'h01;
  localparam logic [7:0] ADDR_CTRL   = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'h03;
  localparam logic [7:0] CTRL_ABORT  = 8'h04;

  localparam int         PCW        = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_MAX_C = PCW'(POLL_MAX);

  // APB bus phase
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // which register access of the current byte is in flight
  typedef enum logic [2:0] {
    STEP_TX,
    STEP_CTRL,
    STEP_POLL,
    STEP_RX,
    STEP_ABORT
  } step_e;

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [2:0]      len_q, len_d;
  logic [47:0]     bytes_q, bytes_d;
  logic [5:0]      mask_q, mask_d;

  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [47:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      paddr_q, paddr_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [7:0]      pwdata_q, pwdata_d;

  logic            last_byte;
  logic            len_legal;
  logic            status_busy;
  logic [PCW-1:0]  poll_cnt_inc;

  assign last_byte    = (byte_idx_q == len_q - 3'd1);
  assign len_legal    = (cmd_len_i != 3'd0) && (cmd_len_i != 3'd7);
  assign status_busy  = prdata_i[0];
  assign poll_cnt_inc = poll_cnt_q + PCW'(1);

  // Next-state sequencing plus decode of the registered APB/handshake outputs.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statements can leave one unassigned and infer a latch.
    state_d     = state_q;
    step_d      = step_q;
    byte_idx_d  = byte_idx_q;
    poll_cnt_d  = poll_cnt_q;
    len_d       = len_q;
    bytes_d     = bytes_q;
    mask_d      = mask_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          len_d      = cmd_len_i;
          bytes_d    = cmd_bytes_i;
          mask_d     = cmd_is_write_i;
          byte_idx_d = 3'd0;
          poll_cnt_d = '0;
          step_d     = STEP_TX;
          rsp_data_d = '0;
          rsp_err_d  = !len_legal;
          state_d    = len_legal ? ST_SETUP : ST_RESP;
        end
      end

      ST_SETUP: state_d = ST_ACCESS;

      ST_ACCESS: begin
        if (pready_i) begin
          state_d = ST_SETUP;
          unique case (step_q)
            STEP_TX:   step_d = STEP_CTRL;
            STEP_CTRL: begin
              step_d     = STEP_POLL;
              poll_cnt_d = '0;
            end
            STEP_POLL: begin
              if (status_busy) begin
                poll_cnt_d = poll_cnt_inc;
                step_d     = (poll_cnt_inc == POLL_MAX_C) ? STEP_ABORT : STEP_POLL;
              end else if (!mask_q[byte_idx_q]) begin
                step_d = STEP_RX;
              end else if (last_byte) begin
                state_d = ST_RESP;
              end else begin
                byte_idx_d = byte_idx_q + 3'd1;
                step_d     = STEP_TX;
              end
            end
            STEP_RX: begin
              rsp_data_d[8*byte_idx_q +: 8] = prdata_i;
              if (last_byte) begin
                state_d = ST_RESP;
              end else begin
                byte_idx_d = byte_idx_q + 3'd1;
                step_d     = STEP_TX;
              end
            end
            STEP_ABORT: begin
              rsp_err_d = 1'b1;
              state_d   = ST_RESP;
            end
            default: state_d = ST_RESP;
          endcase
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered.
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);

    if (state_d == ST_SETUP) begin
      unique case (step_d)
        STEP_TX: begin
          paddr_d  = ADDR_TX;
          pwrite_d = 1'b1;
          pwdata_d = mask_d[byte_idx_d] ? bytes_d[8*byte_idx_d +: 8] : DUMMY_BYTE;
        end
        STEP_CTRL: begin
          paddr_d  = ADDR_CTRL;
          pwrite_d = 1'b1;
          pwdata_d = {6'b0, (byte_idx_d == len_d - 3'd1), 1'b1};
        end
        STEP_POLL: begin
          paddr_d  = ADDR_STATUS;
          pwrite_d = 1'b0;
          pwdata_d = 8'h00;
        end
        STEP_RX: begin
          paddr_d  = ADDR_RX;
          pwrite_d = 1'b0;
          pwdata_d = 8'h00;
        end
        STEP_ABORT: begin
          paddr_d  = ADDR_CTRL;
          pwrite_d = 1'b1;
          pwdata_d = CTRL_ABORT;
        end
        default: begin
          paddr_d  = 8'h00;
          pwrite_d = 1'b0;
          pwdata_d = 8'h00;
        end
      endcase
    end else if (state_d != ST_ACCESS) begin
      // bus quiet outside a transfer; during ACCESS the setup values hold
      paddr_d  = 8'h00;
      pwrite_d = 1'b0;
      pwdata_d = 8'h00;
    end
  end

  // State and output registers; async reset drops the bus immediately.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q     <= ST_IDLE;
      step_q      <= STEP_TX;
      byte_idx_q  <= 3'd0;
      poll_cnt_q  <= '0;
      len_q       <= 3'd0;
      bytes_q     <= '0;
      mask_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= 8'h00;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      step_q      <= step_d;
      byte_idx_q  <= byte_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      len_q       <= len_d;
      bytes_q     <= bytes_d;
      mask_q      <= mask_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_spi_apb_cmd_sequencer.sv
// Scoreboard bench for spi_apb_cmd_sequencer: a reference model expands each
// command into the expected APB transfers and response; an APB slave model
// and a response monitor pop and compare whenever the DUT presents them.
module tb_spi_apb_cmd_sequencer;

  localparam int         POLL_MAX = 4;
  localparam logic [7:0] DUMMY    = 8'hFF;

  logic        clk_i = 1'b0;
  logic        aresetn_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_len_i;
  logic [47:0] cmd_bytes_i;
  logic [5:0]  cmd_is_write_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [47:0] rsp_data_o;
  logic        rsp_err_o;
  logic [7:0]  paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [7:0]  pwdata_o;
  logic        pready_i;
  logic [7:0]  prdata_i;

  spi_apb_cmd_sequencer #(.POLL_MAX(POLL_MAX), .DUMMY_BYTE(DUMMY)) dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_bytes_i(cmd_bytes_i), .cmd_is_write_i(cmd_is_write_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed { logic w; logic [7:0] a; logic [7:0] d; } apb_t;
  typedef struct packed { logic e; logic [47:0] d; } rsp_t;

  apb_t exp_apb[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;

  // slave behaviour for the current command
  int         nbusy[6];
  logic [7:0] rx_tab[6];
  int         wait_mode    = 0;   // 0: zero wait, 1: 3 waits, 2: random 0..3
  int         slave_byte   = -1;
  int         status_reads = 0;
  bit         force_ready  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: expand a command into the APB transfers and response.
  task automatic model(input int len, input logic [47:0] b, input logic [5:0] m);
    rsp_t r;
    r = '0;
    if (len < 1 || len > 6) begin
      r.e = 1'b1;
      exp_rsp.push_back(r);
      return;
    end
    for (int k = 0; k < len; k++) begin
      exp_apb.push_back('{1'b1, 8'h00, m[k] ? b[8*k +: 8] : DUMMY});
      exp_apb.push_back('{1'b1, 8'h02, (k == len - 1) ? 8'h03 : 8'h01});
      if (nbusy[k] >= POLL_MAX) begin
        for (int i = 0; i < POLL_MAX; i++) exp_apb.push_back('{1'b0, 8'h03, 8'h00});
        exp_apb.push_back('{1'b1, 8'h02, 8'h04});
        r.e = 1'b1;
        break;
      end
      for (int i = 0; i <= nbusy[k]; i++) exp_apb.push_back('{1'b0, 8'h03, 8'h00});
      if (!m[k]) begin
        exp_apb.push_back('{1'b0, 8'h01, 8'h00});
        r.d[8*k +: 8] = rx_tab[k];
      end
    end
    exp_rsp.push_back(r);
  endtask

  // APB slave model and transfer monitor.
  initial begin
    apb_t hold, got, e;
    int   wait_left;
    wait_left = 0;
    hold = '0;
    pready_i = 1'b0;
    prdata_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!aresetn_i) begin
        pready_i = 1'b0;
        prdata_i = 8'h00;
      end else if (psel_o && !penable_o) begin
        hold      = {pwrite_o, paddr_o, pwdata_o};
        wait_left = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
        pready_i  = 1'b0;
        prdata_i  = 8'h00;
      end else if (psel_o && penable_o) begin
        got = {pwrite_o, paddr_o, pwdata_o};
        check("apb_hold", 64'(got), 64'(hold));
        if (wait_left > 0) begin
          wait_left--;
          pready_i = 1'b0;
        end else begin
          pready_i = 1'b1;
          prdata_i = 8'h00;
          if (!got.w && got.a == 8'h03) begin
            prdata_i = {7'b0, (slave_byte >= 0 && slave_byte < 6 && status_reads < nbusy[slave_byte])};
            status_reads++;
          end else if (!got.w && got.a == 8'h01 && slave_byte >= 0 && slave_byte < 6) begin
            prdata_i = rx_tab[slave_byte];
          end else if (got.w && got.a == 8'h02 && got.d[0]) begin
            slave_byte++;
            status_reads = 0;
          end
          if (exp_apb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL apb_unexpected: got w=%0b a=%0h d=%0h, none expected", got.w, got.a, got.d);
          end else begin
            e = exp_apb.pop_front();
            check("apb_xfer", 64'(got), 64'(e));
          end
        end
      end else begin
        pready_i = 1'b0;
        prdata_i = 8'h00;
      end
    end
  end

  // Response monitor: drives rsp_ready and compares accepted responses.
  initial begin
    rsp_t held, e;
    bit   pend;
    pend = 1'b0;
    held = '0;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!aresetn_i) begin
        rsp_ready_i = 1'b0;
        pend = 1'b0;
      end else begin
        if (rsp_valid_o && pend) check("rsp_hold", 64'({rsp_err_o, rsp_data_o}), 64'(held));
        rsp_ready_i = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
        if (rsp_valid_o) begin
          if (rsp_ready_i) begin
            pend = 1'b0;
            if (exp_rsp.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected: got err=%0b data=%0h", rsp_err_o, rsp_data_o);
            end else begin
              e = exp_rsp.pop_front();
              check("rsp", 64'({rsp_err_o, rsp_data_o}), 64'(e));
            end
          end else begin
            pend = 1'b1;
            held = {rsp_err_o, rsp_data_o};
          end
        end
      end
    end
  end

  task automatic send_cmd(input int len, input logic [47:0] b, input logic [5:0] m);
    int n;
    n = 0;
    @(negedge clk_i);
    cmd_valid_i    = 1'b1;
    cmd_len_i      = len[2:0];
    cmd_bytes_i    = b;
    cmd_is_write_i = m;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!cmd_ready_o) begin
      fail_now("cmd_accept_timeout");
      cmd_valid_i = 1'b0;
      return;
    end
    slave_byte   = -1;
    status_reads = 0;
    model(len, b, m);
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      if (exp_apb.size() == 0 && exp_rsp.size() == 0 && cmd_ready_o && !rsp_valid_o) return;
    end
    fail_now("done_timeout");
    exp_apb.delete();
    exp_rsp.delete();
  endtask

  task automatic set_slave(input int b0, input int b1, input int b2, input int b3,
                           input int b4, input int b5, input logic [47:0] rx);
    nbusy[0] = b0; nbusy[1] = b1; nbusy[2] = b2;
    nbusy[3] = b3; nbusy[4] = b4; nbusy[5] = b5;
    for (int k = 0; k < 6; k++) rx_tab[k] = rx[8*k +: 8];
  endtask

  initial begin
    int lat;
    int r;
    int len;
    logic [47:0] b;
    logic [5:0]  m;

    aresetn_i      = 1'b0;
    cmd_valid_i    = 1'b0;
    cmd_len_i      = 3'd0;
    cmd_bytes_i    = '0;
    cmd_is_write_i = '0;
    set_slave(0, 0, 0, 0, 0, 0, 48'h0);

    // reset state
    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          64'({cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, psel_o, penable_o, pwrite_o}), 64'(0));
    check("reset_apb_bus", 64'({paddr_o, pwdata_o}), 64'(0));
    #1 aresetn_i = 1'b1;
    check("ready_before_edge", 64'(cmd_ready_o), 64'(0));
    @(posedge clk_i);
    #1 check("ready_after_edge", 64'(cmd_ready_o), 64'(1));

    // 1-byte write, zero wait, latency to rsp_valid
    force_ready = 1'b1;
    wait_mode   = 0;
    set_slave(0, 0, 0, 0, 0, 0, 48'h0);
    send_cmd(1, 48'hA5, 6'b000001);
    lat = 0;
    while (!rsp_valid_o && lat < 50) begin
      @(negedge clk_i);
      lat++;
    end
    check("rsp_latency", 64'(lat), 64'(7));
    wait_done();
    force_ready = 1'b0;

    // 3 bytes: write 9F then two reads, zero wait and then with wait states
    set_slave(0, 0, 0, 0, 0, 0, 48'h0000_0020_C200);
    for (int w = 0; w < 2; w++) begin
      wait_mode = (w == 0) ? 0 : 1;
      send_cmd(3, 48'h0000_0012_349F, 6'b000001);
      wait_done();
    end

    // poll boundary: BUSY for POLL_MAX-1 reads succeeds, POLL_MAX reads times out
    wait_mode = 2;
    set_slave(POLL_MAX - 1, 0, 0, 0, 0, 0, 48'h0);
    send_cmd(1, 48'h3C, 6'b000001);
    wait_done();
    set_slave(100, 0, 0, 0, 0, 0, 48'h0);
    send_cmd(1, 48'h3C, 6'b000001);
    wait_done();
    set_slave(0, 1, POLL_MAX, 0, 0, 0, 48'h0000_0033_2211);
    send_cmd(3, 48'h0, 6'b000000);
    wait_done();

    // illegal lengths
    send_cmd(0, 48'h1234, 6'b111111);
    wait_done();
    send_cmd(7, 48'h1234, 6'b000000);
    wait_done();

    // reset during the second byte's poll
    wait_mode = 1;
    set_slave(0, 3, 0, 0, 0, 0, 48'h0000_0000_7755);
    send_cmd(2, 48'h0, 6'b000000);
    lat = 0;
    while (!(psel_o && penable_o && paddr_o == 8'h03 && slave_byte == 1) && lat < 500) begin
      @(negedge clk_i);
      lat++;
    end
    if (lat >= 500) fail_now("poll_wait_timeout");
    #2 aresetn_i = 1'b0;
    #1 check("async_reset_bus", 64'({psel_o, penable_o, rsp_valid_o, cmd_ready_o}), 64'(0));
    exp_apb.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk_i);
    #1 aresetn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("no_rsp_after_reset", 64'(rsp_valid_o), 64'(0));

    // the next command executes normally
    wait_mode = 0;
    set_slave(1, 0, 0, 0, 0, 0, 48'h0000_0000_00E7);
    send_cmd(2, 48'h0000_0000_5A00, 6'b000010);
    wait_done();

    // randomized commands against the model
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 19));
      len = (r == 0) ? 0 : (r == 1) ? 7 : int'($urandom_range(1, 6));
      b[31:0]  = $urandom();
      b[47:32] = 16'($urandom());
      m = 6'($urandom());
      for (int k = 0; k < 6; k++) begin
        nbusy[k]  = ($urandom_range(0, 9) == 0) ? POLL_MAX + int'($urandom_range(0, 1)) :
                                                  int'($urandom_range(0, POLL_MAX - 1));
        rx_tab[k] = 8'($urandom());
      end
      wait_mode = int'($urandom_range(0, 2));
      send_cmd(len, b, m);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
